// File: rtl/xpt_sequencer_if.sv
// Bus between xpt_sequencer and its downstream instruction decoders.
// master = sequencer side, slave = decoder/memory side.
interface xpt_sequencer_if #(
    parameter int unsigned XPT_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] MEM_Data;
    logic                  MEM_Ready;
    logic                  MEM_Wait;
    logic                  OP_Load;
    logic                  Req_Reset_XPT;
    logic                  Req_Set_CM1;
    logic                  Req_Reset_ITABLE;
    logic                  Req_Ophd;

    logic [XPT_WIDTH-1:0]  XPT;
    logic [XPT_WIDTH-1:0]  notXPT;
    logic [DATA_WIDTH-1:0] ITABLE;
    logic [DATA_WIDTH-1:0] notITABLE;
    logic                  OP7;
    logic                  notOP7;
    logic [DATA_WIDTH-1:0] OP;
    logic                  CM1;
    logic                  Decoder_enable;
    logic                  XPT_Overflow;

    modport master (
        input  MEM_Data, MEM_Ready, MEM_Wait, OP_Load,
               Req_Reset_XPT, Req_Set_CM1, Req_Reset_ITABLE, Req_Ophd,
        output XPT, notXPT, ITABLE, notITABLE, OP7, notOP7, OP,
               CM1, Decoder_enable, XPT_Overflow
    );

    modport slave (
        output MEM_Data, MEM_Ready, MEM_Wait, OP_Load,
               Req_Reset_XPT, Req_Set_CM1, Req_Reset_ITABLE, Req_Ophd,
        input  XPT, notXPT, ITABLE, notITABLE, OP7, notOP7, OP,
               CM1, Decoder_enable, XPT_Overflow
    );
endinterface

// File: rtl/xpt_sequencer.sv
// Execution-phase sequencer: owns XPT step counter, ITABLE, OP and CM1.
// Optional macro XPT_WATCHDOG_EN: overflow aborts to FETCH with a one-cycle flag pulse.
module xpt_sequencer #(
    parameter int unsigned           XPT_WIDTH   = 4,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] ITABLE_IDLE = '0
) (
    input logic CLK,
    input logic RESET,
    xpt_sequencer_if.master bus
);
    typedef enum logic {FETCH, EXEC} state_t;

    state_t                state, state_nxt;
    logic [XPT_WIDTH-1:0]  xpt, xpt_nxt;
    logic [DATA_WIDTH-1:0] itable, itable_nxt;
    logic [DATA_WIDTH-1:0] op, op_nxt;
    logic                  ovf, ovf_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= FETCH;
            xpt    <= '0;
            itable <= ITABLE_IDLE;
            op     <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            xpt    <= xpt_nxt;
            itable <= itable_nxt;
            op     <= op_nxt;
            ovf    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        xpt_nxt    = xpt;
        itable_nxt = itable;
        op_nxt     = op;
`ifdef XPT_WATCHDOG_EN
        ovf_nxt    = 1'b0;
`else
        ovf_nxt    = ovf;
`endif
        case (state)
            FETCH: begin
                if (bus.MEM_Ready) begin
                    itable_nxt = bus.MEM_Data;
                    xpt_nxt    = '0;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (bus.OP_Load && bus.MEM_Ready)
                    op_nxt = bus.MEM_Data;
                if (bus.Req_Reset_XPT) begin
                    xpt_nxt = '0;
                    if (bus.Req_Reset_ITABLE)
                        itable_nxt = ITABLE_IDLE;
                    // Overlapped fetch beats both the ITABLE reset and the return to FETCH
                    if (bus.Req_Ophd && bus.MEM_Ready)
                        itable_nxt = bus.MEM_Data;
                    else if (bus.Req_Set_CM1)
                        state_nxt = FETCH;
                end else if (!bus.MEM_Wait) begin
                    if (xpt == '1) begin
`ifdef XPT_WATCHDOG_EN
                        xpt_nxt    = '0;
                        itable_nxt = ITABLE_IDLE;
                        state_nxt  = FETCH;
                        ovf_nxt    = 1'b1;
`else
                        ovf_nxt    = 1'b1;
`endif
                    end else begin
                        xpt_nxt = xpt + 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.XPT            = xpt;
    assign bus.notXPT         = ~xpt;
    assign bus.ITABLE         = itable;
    assign bus.notITABLE      = ~itable;
    assign bus.OP             = op;
    assign bus.OP7            = op[DATA_WIDTH-1];
    assign bus.notOP7         = ~op[DATA_WIDTH-1];
    assign bus.CM1            = (state == FETCH);
    assign bus.Decoder_enable = (state == EXEC);
    assign bus.XPT_Overflow   = ovf;
endmodule

// File: doc/xpt_sequencer.md
Name: xpt_sequencer

Overview:
- Execution-phase sequencer directly upstream of the per-group instruction decoders, for example the JR/DJNZ group.
- Owns the XPT step counter, the ITABLE opcode register, the OP operand register and the CM1 (opcode-fetch) flag.
- Drives each of these to the decoders in both true and complemented form, plus the decoder enable.
- Consumes the decoders' end-of-instruction requests: reset XPT, set CM1, reset ITABLE, operand-head overlap.

Parameters:
XPT_WIDTH, 4, width of step counter XPT
DATA_WIDTH, 8, width of ITABLE, OP and memory data
ITABLE_IDLE, 8'h00, value loaded into ITABLE on reset or on Req_Reset_ITABLE

Ports:
CLK  in  1  single system clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
MEM_Data  in  8  byte from memory bus
MEM_Ready  in  1  MEM_Data valid this cycle
MEM_Wait  in  1  memory stall; freezes XPT advance
OP_Load  in  1  decoder request to latch MEM_Data into OP
Req_Reset_XPT  in  1  OR of decoders' PR_Reset_XPT
Req_Set_CM1  in  1  OR of decoders' P2_Set_CM1
Req_Reset_ITABLE  in  1  OR of decoders' P2_Reset_ITABLE
Req_Ophd  in  1  OR of decoders' Pa_Ophd (next opcode already on bus)
XPT / notXPT  out  4 / 4  step counter and its complement
ITABLE / notITABLE  out  8 / 8  current opcode and its complement
OP7 / notOP7  out  1 / 1  OP[7] and its complement
OP  out  8  operand register
CM1  out  1  high during opcode-fetch state
Decoder_enable  out  1  high in EXEC state
XPT_Overflow  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, CLK; RESET is synchronous and active-high.
- Reset values: state=FETCH, CM1=1, XPT=0, ITABLE=ITABLE_IDLE, OP=0, Decoder_enable=0, XPT_Overflow=0.
- Complement outputs are always the exact bitwise inverse of their registers, including during reset.
- States: FETCH, EXEC. CM1 = (state==FETCH); Decoder_enable = (state==EXEC). Both are registered-state decodes with no combinational input path.

FETCH:
- Each cycle with MEM_Ready=1: ITABLE<=MEM_Data, XPT<=0, state<=EXEC.
- MEM_Ready=0: hold all registers.
- Decoder requests are ignored in FETCH.

EXEC, priority per cycle, highest first:
1. Req_Reset_XPT=1:
   - XPT<=0.
   - If Req_Reset_ITABLE: ITABLE<=ITABLE_IDLE.
   - If Req_Ophd && MEM_Ready: ITABLE<=MEM_Data and stay in EXEC (overlapped fetch, zero-cycle gap). This overrides the ITABLE reset.
   - Else if Req_Set_CM1: state<=FETCH.
   - Else: stay in EXEC with XPT=0.
2. MEM_Wait=1: XPT holds.
3. Otherwise XPT<=XPT+1, saturating at 15. An increment attempted at 15 sets XPT_Overflow.

OP register:
- OP<=MEM_Data when state==EXEC && OP_Load && MEM_Ready.
- Independent of the XPT priority list; may coincide with Req_Reset_XPT.

General rules:
- Latency: every request takes effect at the next rising edge; no combinational path from any Req_* input to any output.
- XPT_Overflow is cleared only by RESET.
- RESET asserted mid-instruction wins over every other input in that cycle.

Optional Feature:
- Macro XPT_WATCHDOG_EN.
- Defined: an increment attempted at XPT=15 in EXEC instead forces XPT<=0, ITABLE<=ITABLE_IDLE, state<=FETCH, and pulses XPT_Overflow high for exactly one cycle (not sticky).
- Undefined: saturate and set the sticky flag as described in Behaviour.

Test Plan:
1. Reset then fetch:
   - Stimulus: RESET 1 cycle; MEM_Data=8'h18, MEM_Ready=1.
   - Response: next cycle CM1=0, Decoder_enable=1, ITABLE=8'h18, notITABLE=8'hE7, XPT=0; XPT reads 1, 2, 3 on following cycles.
2. Stall:
   - Stimulus: in EXEC at XPT=2, MEM_Wait=1 for 3 cycles.
   - Response: XPT stays 2, then advances to 3.
3. End of instruction:
   - Stimulus: at XPT=4, Req_Reset_XPT=Req_Set_CM1=Req_Reset_ITABLE=1.
   - Response: next cycle CM1=1, XPT=0, ITABLE=8'h00, Decoder_enable=0.
4. Overlapped fetch:
   - Stimulus: Req_Reset_XPT=Req_Ophd=Req_Set_CM1=1, MEM_Ready=1, MEM_Data=8'h10.
   - Response: CM1 stays 0, ITABLE=8'h10, XPT=0.
5. Operand latch:
   - Stimulus: OP_Load=1, MEM_Ready=1, MEM_Data=8'hFE.
   - Response: OP=8'hFE, OP7=1, notOP7=0.
   - Then: OP_Load with MEM_Ready=0 leaves OP unchanged.
6. Runaway plus mid-run reset:
   - Stimulus: EXEC with no requests for 16 cycles.
   - Response without macro: XPT=15, XPT_Overflow=1 (sticky).
   - Response with XPT_WATCHDOG_EN: CM1=1 and a one-cycle XPT_Overflow pulse.
   - Then: RESET at XPT=7 gives all reset values next cycle.
